// File: rtl/four_onedemux_tdm.sv
`default_nettype none
// ============================================================================
// Module      : four_onedemux_tdm
// Description : Serial 4-slot TDM bit stream to four parallel WIDTH-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module four_onedemux_tdm #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               sync,
  output logic [1:0]         slot,
  output logic [4*WIDTH-1:0] dout,
  output logic               out_valid,
  output logic               locked,
  output logic               sync_err
);

  localparam int                FCNT_W    = $clog2(WIDTH);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(WIDTH - 1);
  localparam logic [1:0]        SLOT_LAST = 2'd3;

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [WIDTH-1:0]   sr_q [4];
  logic [WIDTH-1:0]   sr_d [4];
  logic [4*WIDTH-1:0] dout_q, dout_d;
  logic               out_valid_q, out_valid_d;
  logic               sync_err_q, sync_err_d;

  logic restart;
  logic shift_en;

  // A sync realigns the frame unless it lands on an already-expected slot 0.
  assign restart  = din_valid && sync && ((state_q == ST_HUNT) || (slot_q != 2'd0));
  assign shift_en = din_valid && (state_q == ST_LOCK) && !restart;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: any qualified sync locks; nothing returns to HUNT but reset
  always_comb begin
    state_d = state_q;
    if (din_valid && sync) begin
      state_d = ST_LOCK;
    end
  end

  // Output logic
  always_comb begin
    locked = (state_q == ST_LOCK);
  end

  // Datapath next-state
  always_comb begin
    slot_d      = slot_q;
    fcnt_d      = fcnt_q;
    dout_d      = dout_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sr_d[k] = sr_q[k];
    end

    if (restart) begin
      for (int k = 0; k < 4; k++) begin
        sr_d[k] = '0;
      end
      sr_d[0]    = {{(WIDTH-1){1'b0}}, din};
      slot_d     = 2'd1;
      fcnt_d     = '0;
      sync_err_d = (state_q == ST_LOCK);
    end else if (shift_en) begin
      sr_d[slot_q] = {sr_q[slot_q][WIDTH-2:0], din};
      slot_d       = slot_q + 2'd1;
      if (slot_q == SLOT_LAST) begin
        if (fcnt_q == FCNT_LAST) begin
          fcnt_d      = '0;
          dout_d      = {sr_d[3], sr_d[2], sr_d[1], sr_d[0]};
          out_valid_d = 1'b1;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= 2'd0;
      fcnt_q      <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        sr_q[k] <= '0;
      end
    end else begin
      slot_q      <= slot_d;
      fcnt_q      <= fcnt_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      for (int k = 0; k < 4; k++) begin
        sr_q[k] <= sr_d[k];
      end
    end
  end

  assign slot      = slot_q;
  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_four_onedemux_tdm.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_onedemux_tdm
// Description : Directed and random checks of four_onedemux_tdm (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_onedemux_tdm;

  localparam int W  = 8;
  localparam int NB = 4 * W;

  logic          clk;
  logic          rst_n;
  logic          din;
  logic          din_valid;
  logic          sync;
  logic [1:0]    slot;
  logic [NB-1:0] dout;
  logic          out_valid;
  logic          locked;
  logic          sync_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ov_count = 0;
  int err_count = 0;

  // Reference model: bits collected since the last frame alignment point.
  bit            m_locked;
  int            m_n;
  bit            m_bits [NB];
  logic [NB-1:0] m_dout;
  bit            m_ov;
  bit            m_err;

  four_onedemux_tdm #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .sync      (sync),
    .slot      (slot),
    .dout      (dout),
    .out_valid (out_valid),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_n      = 0;
    m_dout   = '0;
    m_ov     = 0;
    m_err    = 0;
    for (int i = 0; i < NB; i++) m_bits[i] = 0;
  endtask

  task automatic model_step(input bit d, input bit v, input bit s);
    m_ov  = 0;
    m_err = 0;
    if (!v) return;
    if (s && (!m_locked || (m_n % 4) != 0)) begin
      m_err    = m_locked;
      m_locked = 1;
      for (int i = 0; i < NB; i++) m_bits[i] = 0;
      m_bits[0] = d;
      m_n       = 1;
    end else if (m_locked) begin
      m_bits[m_n] = d;
      m_n++;
      if (m_n == NB) begin
        // Bit 4f+k of the group is channel k, frame f; frame 0 carries the MSB.
        for (int k = 0; k < 4; k++)
          for (int f = 0; f < W; f++)
            m_dout[k*W + (W-1-f)] = m_bits[4*f + k];
        m_ov = 1;
        m_n  = 0;
      end
    end
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_slot"},      {62'd0, slot}, 64'(m_n % 4));
    check({pfx, "_locked"},    {63'd0, locked}, {63'd0, m_locked});
    check({pfx, "_out_valid"}, {63'd0, out_valid}, {63'd0, m_ov});
    check({pfx, "_sync_err"},  {63'd0, sync_err}, {63'd0, m_err});
    check({pfx, "_dout"},      64'(dout), 64'(m_dout));
  endtask

  task automatic send(input logic d, input logic v, input logic s);
    din       = d;
    din_valid = v;
    sync      = s;
    @(posedge clk);
    #1;
    model_step(d, v, s);
    check_outputs("cyc");
    if (out_valid === 1'b1) ov_count++;
    if (sync_err === 1'b1) err_count++;
  endtask

  // Reset is applied and checked between clock edges to exercise its asynchrony.
  task automatic do_reset();
    din_valid = 1'b0;
    sync      = 1'b0;
    rst_n     = 1'b0;
    #2;
    model_reset();
    check_outputs("rst");
    rst_n = 1'b1;
    #1;
  endtask

  task automatic send_word(input logic [NB-1:0] words, input bit sync_each, input int gap);
    for (int f = 0; f < W; f++) begin
      for (int k = 0; k < 4; k++) begin
        send(words[k*W + (W-1-f)], 1'b1, (f == 0 && k == 0) || (sync_each && k == 0));
        for (int g = 0; g < gap; g++) send(1'($urandom), 1'b0, 1'($urandom));
      end
    end
  endtask

  localparam logic [NB-1:0] WORD_A = 32'h01FF3CA5;
  localparam logic [NB-1:0] WORD_B = 32'h5AC300FE;
  localparam logic [NB-1:0] WORD_C = 32'h96817E24;

  initial begin
    rst_n     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    sync      = 1'b0;
    #3;
    do_reset();

    // Single framed word
    ov_count = 0;
    send_word(WORD_A, 1'b0, 0);
    check("t1_ov_count", 64'(ov_count), 64'd1);
    check("t1_dout", 64'(dout), 64'(WORD_A));

    // No sync: nothing accepted
    do_reset();
    ov_count = 0;
    for (int i = 0; i < 10; i++) send(1'($urandom), 1'b1, 1'b0);
    check("t2_locked", {63'd0, locked}, 64'd0);
    check("t2_slot", {62'd0, slot}, 64'd0);
    check("t2_ov_count", 64'(ov_count), 64'd0);

    // Gaps between qualified bits
    do_reset();
    ov_count = 0;
    send_word(WORD_A, 1'b0, 3);
    check("t3_ov_count", 64'(ov_count), 64'd1);
    check("t3_dout", 64'(dout), 64'(WORD_A));

    // Misaligned sync at slot 1 of the second frame
    do_reset();
    ov_count  = 0;
    err_count = 0;
    send(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(1'($urandom), 1'b1, 1'b0);
    send_word(WORD_B, 1'b0, 0);
    check("t4_err_count", 64'(err_count), 64'd1);
    check("t4_ov_count", 64'(ov_count), 64'd1);
    check("t4_dout", 64'(dout), 64'(WORD_B));

    // Reset mid-word
    do_reset();
    ov_count = 0;
    send(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 19; i++) send(1'($urandom), 1'b1, 1'b0);
    do_reset();
    send_word(WORD_C, 1'b0, 0);
    check("t5_ov_count", 64'(ov_count), 64'd1);
    check("t5_dout", 64'(dout), 64'(WORD_C));

    // Back-to-back words with sync on every slot 0
    do_reset();
    ov_count  = 0;
    err_count = 0;
    send_word(WORD_B, 1'b1, 0);
    send_word(WORD_C, 1'b1, 0);
    check("t6_ov_count", 64'(ov_count), 64'd2);
    check("t6_err_count", 64'(err_count), 64'd0);
    check("t6_dout", 64'(dout), 64'(WORD_C));

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        logic v, s;
        v = ($urandom_range(0, 3) != 0);
        if ((m_n % 4) == 0) s = ($urandom_range(0, 1) == 0);
        else                s = ($urandom_range(0, 59) == 0);
        send(1'($urandom), v, s);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/four_onedemux_tdm.md
FOUR_ONEDEMUX_TDM -- requirements
Module: four_onedemux_tdm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the bits per channel word (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port din, input, 1, the serial time-division-multiplexed bit, four slots per frame (slot 0..3 = channel 0..3).
REQ-005 The block SHALL have port din_valid, input, 1, qualifying din and sync for one clock.
REQ-006 The block SHALL have port sync, input, 1, marking the qualified bit as slot 0 of a frame.
REQ-007 The block SHALL have port slot, output, 2, the slot index that the next qualified bit will occupy.
REQ-008 The block SHALL have port dout, output, 4*WIDTH, with channel k word on dout[k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port out_valid, output, 1, a one-cycle pulse when dout is updated.
REQ-010 The block SHALL have port locked, output, 1, high in state LOCK.
REQ-011 The block SHALL have port sync_err, output, 1, a one-cycle pulse on a misaligned sync.

Function
REQ-012 The block SHALL implement states HUNT and LOCK; locked SHALL be 1 only in LOCK.
REQ-013 In HUNT, qualified bits without sync SHALL be discarded with no change to any register.
REQ-014 In HUNT, a qualified bit with sync SHALL move the block to LOCK and be stored as channel 0, bit position 0 of a new word (slot becomes 1, frame count 0).
REQ-015 In LOCK, each qualified bit SHALL be shifted MSB-first into the channel-slot shift register, and slot SHALL advance, wrapping 3->0.
REQ-016 A frame counter (0..WIDTH-1) SHALL increment on each qualified slot-3 bit, wrapping to 0 after WIDTH-1.
REQ-017 On the qualified slot-3 bit when the frame count is WIDTH-1, the next rising edge SHALL load all four assembled words (including that bit) into dout and assert out_valid for exactly one cycle.
REQ-018 dout SHALL hold its value between out_valid pulses.
REQ-019 A qualified sync in LOCK with slot==0 SHALL be accepted silently, with normal operation.
REQ-020 A qualified sync in LOCK with slot!=0 SHALL pulse sync_err, discard all partial words (frame count 0), store the bit as channel 0 bit position 0, set slot to 1, and keep the block in LOCK; no out_valid SHALL result from the discarded words.
REQ-021 If a sync occurs on the same bit that completes a word, sync_err SHALL take priority and out_valid SHALL not pulse for that word.
REQ-022 sync or din with din_valid=0 SHALL be ignored; gaps of any length between qualified bits SHALL not affect state.
REQ-023 out_valid and sync_err SHALL be registered outputs.

Reset
REQ-024 Asserting rst_n=0 at any time, including mid-word, SHALL immediately set state HUNT, slot=0, frame count=0, all shift registers=0, dout=0, out_valid=0, sync_err=0, and locked=0.
REQ-025 After rst_n deasserts, the first rising edge SHALL behave as in HUNT, and a sync is required before any bit is accepted.

Verification (WIDTH=8)
REQ-026 Reset then 32 qualified bits with sync on bit 0, carrying ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x01 -> one cycle after bit 32, out_valid=1 with dout={0x01,0xFF,0x3C,0xA5}, and locked=1 from bit 1 on.
REQ-027 Ten qualified bits without sync after reset -> locked=0, slot=0, and out_valid is never asserted.
REQ-028 Same frame stream as REQ-026 with din_valid low for 3 cycles between every bit -> identical dout and a single out_valid.
REQ-029 sync asserted on bit 6 of a frame (slot 1) -> sync_err pulses once, and the following 32 bits yield exactly one correct out_valid word.
REQ-030 Assert rst_n=0 after bit 20, then release and send a full 32-bit framed stream -> no out_valid before completion, then the correct dout.
REQ-031 Two back-to-back 32-bit words with sync on every frame slot 0 -> two out_valid pulses 32 qualified bits apart, and sync_err is never asserted.
